ucore_input_buffers: RTL and testbench
======================================

// Module: ucore_input_buffers
// PURPOSE
//  Per-operand input stage of the RipTide ucore: NUM_INPUTS independent NoC
//  channels, each with a DEPTH-entry FIFO and valid/ready handshake. Each channel
//  can be configured as a constant operand that is always valid and never drained.
//  Sits between the NoC input ports and the ucore firing/ALU logic; the ucore pops
//  operands with a per-channel consume strobe.
// PARAMETERS
//  DATA_WIDTH  32  width of one operand token
//  NUM_INPUTS  2   number of input channels (>=1)
//  DEPTH       2   FIFO entries per channel (power of 2, >=2)
// PORTS
//  clk            in   1                     clock; all logic on rising edge
//  reset          in   1                     synchronous, active-high reset
//  cfg_we         in   1                     load cfg_const_en/cfg_const_val this cycle
//  cfg_const_en   in   NUM_INPUTS            per-channel constant-mode enable
//  cfg_const_val  in   NUM_INPUTS*DATA_WIDTH per-channel constant value (ch i at [i*W +: W])
//  noc_ivalid     in   NUM_INPUTS            NoC token valid, per channel
//  noc_in         in   NUM_INPUTS*DATA_WIDTH NoC token data, packed as cfg_const_val
//  noc_oready     out  NUM_INPUTS            channel can accept a token
//  out_valid      out  NUM_INPUTS            head-of-channel operand available
//  out_data       out  NUM_INPUTS*DATA_WIDTH head operand, packed as cfg_const_val
//  consume        in   NUM_INPUTS            ucore pops head operand of channel i
//  occupancy      out  NUM_INPUTS*($clog2(DEPTH)+1) per-channel entry count
// BEHAVIOUR
//  Reset: all FIFOs empty, pointers 0, const mode off, const values 0.
//   After reset: out_valid=0, out_data=0, occupancy=0, noc_oready=all 1.
//  Handshake: push on channel i when noc_ivalid[i] && noc_oready[i].
//   Pop when consume[i] && out_valid[i]; consume while !out_valid is ignored.
//   noc_ivalid/noc_in are ignored when noc_oready is low; producer holds data.
//  FIFO mode, channel i (cfg_const_en[i]=0):
//   noc_oready[i] = (count < DEPTH); it depends only on state, not on consume
//    (no pass-through when full).
//   out_valid[i] = (count != 0); out_data[i] = entry at read pointer, else 0.
//   Latency: a pushed token is visible at the output the cycle after the push edge.
//    No bypass: a push into an empty channel does not show the token in the same cycle.
//   Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
//   Pointers wrap modulo DEPTH. Order is strict FIFO.
//   count tracks 0..DEPTH and is never exceeded or underflowed.
//  Const mode, channel i (cfg_const_en[i]=1):
//   noc_oready[i]=0, out_valid[i]=1, out_data[i]=const value.
//   consume[i] has no effect; the FIFO is not touched.
//  Config: on a cycle with cfg_we=1, every channel registers its const_en and const_val.
//   Every FIFO is flushed: count=0, pointers=0, stored data discarded.
//   Any push or pop in that same cycle is dropped.
//   The new mode takes effect from the next cycle.
//  Reset wins over cfg_we and over all handshakes.
//   Reset mid-operation discards every buffered token.
//  Channels are fully independent; there is no cross-channel dependency.
//  occupancy[i] = count in FIFO mode, 0 in const mode.
// TESTING
//  1) Reset, then idle -> out_valid=0, noc_oready=all 1, occupancy=0 on every channel.
//  2) Ch0: push 0xA,0xB (DEPTH=2), no consume -> oready[0]=0 after the 2nd push.
//     A 3rd token 0xC held valid is not taken.
//     Then consume twice -> out_data 0xA then 0xB, in order.
//  3) Ch1 holds 1 entry; push 0x5 and consume in the same cycle.
//     -> occupancy stays 1, and out_data shows 0x5 next.
//     Run 10 wraps with no loss or reorder.
//  4) cfg_we with const_en=2'b01, const_val[0]=0x1234
//     -> out_valid[0]=1, data 0x1234, oready[0]=0.
//     Stays valid after 5 consume pulses; ch1 unaffected apart from the flush.
//  5) Ch0 full, then cfg_we with const_en=0
//     -> occupancy 0, out_valid 0 next cycle, earlier data never emitted.
//  6) Assert reset while both channels hold data and pushes are in flight
//     -> all reset values next cycle, and in-flight tokens are not stored.

Source files
------------

// File: rtl/ucore_input_buffers.sv
// ucore_input_buffers: per-operand input stage of the ucore.
// NUM_INPUTS independent channels, each a DEPTH-entry FIFO with a valid/ready
// handshake on the NoC side and a consume strobe on the ucore side. A channel
// can be switched into constant mode, where it always presents a configured
// value and is never drained.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   cfg_we          load cfg_const_en/cfg_const_val and flush every FIFO
//   cfg_const_en    per-channel constant-mode enable
//   cfg_const_val   per-channel constant value, channel i at [i*W +: W]
//   noc_ivalid      per-channel NoC token valid
//   noc_in          per-channel NoC token data, packed like cfg_const_val
//   noc_oready      per-channel "can accept a token"
//   out_valid       per-channel head operand available
//   out_data        per-channel head operand, packed like cfg_const_val
//   consume         per-channel pop of the head operand
//   occupancy       per-channel entry count (0 in constant mode)
// Every output is decoded only from registered state, so there is no
// combinational path from any input to any output.
module ucore_input_buffers #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cfg_we,
    input  logic [NUM_INPUTS-1:0]                     cfg_const_en,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          cfg_const_val,
    input  logic [NUM_INPUTS-1:0]                     noc_ivalid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          noc_in,
    output logic [NUM_INPUTS-1:0]                     noc_oready,
    output logic [NUM_INPUTS-1:0]                     out_valid,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]          out_data,
    input  logic [NUM_INPUTS-1:0]                     consume,
    output logic [NUM_INPUTS*($clog2(DEPTH)+1)-1:0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    genvar i;
    generate
        for (i = 0; i < NUM_INPUTS; i++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]         rd_ptr;
            logic [PW-1:0]         wr_ptr;
            logic [CW-1:0]         count;
            logic                  const_en;
            logic [DATA_WIDTH-1:0] const_val;
            logic                  push;
            logic                  pop;
            logic                  not_empty;

            assign not_empty = (count != '0);

            // Ready depends on state only: a full FIFO never passes a token through.
            assign noc_oready[i] = !const_en && (count < CW'(DEPTH));
            assign out_valid[i]  = const_en || not_empty;
            assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
                const_en ? const_val : (not_empty ? mem[rd_ptr] : '0);
            assign occupancy[i*CW +: CW] = const_en ? '0 : count;

            // A config write flushes the FIFO, so any handshake in that cycle is dropped.
            assign push = noc_ivalid[i] && noc_oready[i] && !cfg_we;
            assign pop  = consume[i] && !const_en && not_empty && !cfg_we;

            // Storage carries no reset; stale entries are hidden by count.
            always_ff @(posedge clk) begin
                if (push && !reset) begin
                    mem[wr_ptr] <= noc_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // Pointer, count and configuration state.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_ptr    <= '0;
                    wr_ptr    <= '0;
                    count     <= '0;
                    const_en  <= 1'b0;
                    const_val <= '0;
                end else if (cfg_we) begin
                    rd_ptr    <= '0;
                    wr_ptr    <= '0;
                    count     <= '0;
                    const_en  <= cfg_const_en[i];
                    const_val <= cfg_const_val[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    // Pointers wrap naturally since DEPTH is a power of two.
                    if (push) wr_ptr <= wr_ptr + PW'(1);
                    if (pop)  rd_ptr <= rd_ptr + PW'(1);
                    case ({push, pop})
                        2'b10:   count <= count + CW'(1);
                        2'b01:   count <= count - CW'(1);
                        default: count <= count;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ucore_input_buffers.sv
// Directed self-checking bench for ucore_input_buffers (DATA_WIDTH=32,
// NUM_INPUTS=2, DEPTH=2). Inputs are driven and outputs sampled 1ns after
// each rising edge.
module tb_ucore_input_buffers;

    localparam int unsigned W = 32;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_const_en;
    logic [63:0] cfg_const_val;
    logic [1:0]  noc_ivalid;
    logic [63:0] noc_in;
    logic [1:0]  noc_oready;
    logic [1:0]  out_valid;
    logic [63:0] out_data;
    logic [1:0]  consume;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    ucore_input_buffers #(.DATA_WIDTH(32), .NUM_INPUTS(2), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_const_en  (cfg_const_en),
        .cfg_const_val (cfg_const_val),
        .noc_ivalid    (noc_ivalid),
        .noc_in        (noc_in),
        .noc_oready    (noc_oready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .consume       (consume),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
        checks++;
        if (noc_oready !== 2'b11) begin errors++; $display("FAIL reset_oready got=%b exp=11", noc_oready); end
        checks++;
        if (occupancy !== 4'h0) begin errors++; $display("FAIL reset_occ got=%h exp=0", occupancy); end
        checks++;
        if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    endtask

    task automatic test_fill_drain();
        noc_ivalid = 2'b01;
        noc_in     = 64'h0000_000A;
        step();
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'hA) begin
            errors++; $display("FAIL fill_first got v=%b d=%h exp v=1 d=a", out_valid[0], out_data[31:0]);
        end
        noc_in = 64'h0000_000B;
        step();
        checks++;
        if (noc_oready[0] !== 1'b0 || occupancy[1:0] !== 2'd2) begin
            errors++; $display("FAIL fill_full got rdy=%b occ=%0d exp rdy=0 occ=2", noc_oready[0], occupancy[1:0]);
        end
        noc_in = 64'h0000_000C;
        step();
        checks++;
        if (occupancy[1:0] !== 2'd2 || out_data[31:0] !== 32'hA) begin
            errors++; $display("FAIL fill_hold got occ=%0d d=%h exp occ=2 d=a", occupancy[1:0], out_data[31:0]);
        end
        noc_ivalid = 2'b00;
        consume    = 2'b01;
        step();
        checks++;
        if (out_data[31:0] !== 32'hB || occupancy[1:0] !== 2'd1) begin
            errors++; $display("FAIL drain_second got d=%h occ=%0d exp d=b occ=1", out_data[31:0], occupancy[1:0]);
        end
        step();
        consume = 2'b00;
        checks++;
        if (out_valid[0] !== 1'b0 || occupancy[1:0] !== 2'd0 || noc_oready[0] !== 1'b1) begin
            errors++; $display("FAIL drain_empty got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1",
                               out_valid[0], occupancy[1:0], noc_oready[0]);
        end
    endtask

    task automatic test_back_to_back();
        noc_ivalid = 2'b10;
        noc_in     = {32'h0000_0001, 32'h0};
        step();
        // 20 simultaneous push/pop cycles = 10 pointer wraps at DEPTH=2.
        for (int k = 0; k < 20; k++) begin
            noc_in  = {32'h100 + 32'(k), 32'h0};
            consume = 2'b10;
            step();
            checks++;
            if (occupancy[3:2] !== 2'd1 || out_data[63:32] !== 32'h100 + 32'(k)) begin
                errors++; $display("FAIL b2b_%0d got occ=%0d d=%h exp occ=1 d=%h",
                                   k, occupancy[3:2], out_data[63:32], 32'h100 + 32'(k));
            end
        end
        noc_ivalid = 2'b00;
        step();
        consume = 2'b00;
        checks++;
        if (out_valid[1] !== 1'b0 || occupancy[3:2] !== 2'd0) begin
            errors++; $display("FAIL b2b_drain got v=%b occ=%0d exp v=0 occ=0", out_valid[1], occupancy[3:2]);
        end
    endtask

    task automatic test_const();
        noc_ivalid = 2'b10;
        noc_in     = {32'h77, 32'h0};
        step();
        // Config write with a concurrent ch1 push that must be dropped.
        cfg_we        = 1'b1;
        cfg_const_en  = 2'b01;
        cfg_const_val = {32'h0, 32'h1234};
        noc_in        = {32'h99, 32'h0};
        step();
        cfg_we     = 1'b0;
        noc_ivalid = 2'b00;
        checks++;
        if (out_valid !== 2'b01 || out_data[31:0] !== 32'h1234 || noc_oready !== 2'b10) begin
            errors++; $display("FAIL const_load got v=%b d=%h rdy=%b exp v=01 d=1234 rdy=10",
                               out_valid, out_data[31:0], noc_oready);
        end
        checks++;
        if (occupancy !== 4'h0) begin errors++; $display("FAIL const_flush got occ=%h exp 0", occupancy); end
        consume = 2'b11;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 2'b01 || out_data[31:0] !== 32'h1234) begin
                errors++; $display("FAIL const_consume_%0d got v=%b d=%h exp v=01 d=1234",
                                   k, out_valid, out_data[31:0]);
            end
        end
        consume = 2'b00;
    endtask

    task automatic test_const_off();
        cfg_we        = 1'b1;
        cfg_const_en  = 2'b00;
        cfg_const_val = 64'h0;
        step();
        cfg_we = 1'b0;
        checks++;
        if (out_valid !== 2'b00 || noc_oready !== 2'b11) begin
            errors++; $display("FAIL off_mode got v=%b rdy=%b exp v=00 rdy=11", out_valid, noc_oready);
        end
        noc_ivalid = 2'b01;
        noc_in     = {32'h0, 32'hD1};
        step();
        noc_in = {32'h0, 32'hD2};
        step();
        noc_ivalid = 2'b00;
        checks++;
        if (occupancy[1:0] !== 2'd2) begin errors++; $display("FAIL off_full got occ=%0d exp 2", occupancy[1:0]); end
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        checks++;
        if (occupancy[1:0] !== 2'd0 || out_valid[0] !== 1'b0 || out_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL off_flush got occ=%0d v=%b d=%h exp occ=0 v=0 d=0",
                               occupancy[1:0], out_valid[0], out_data[31:0]);
        end
        noc_ivalid = 2'b01;
        noc_in     = {32'h0, 32'hE1};
        step();
        noc_ivalid = 2'b00;
        checks++;
        if (out_data[31:0] !== 32'hE1 || occupancy[1:0] !== 2'd1) begin
            errors++; $display("FAIL off_fresh got d=%h occ=%0d exp d=e1 occ=1", out_data[31:0], occupancy[1:0]);
        end
    endtask

    task automatic test_reset_mid();
        noc_ivalid = 2'b11;
        noc_in     = {32'hF2, 32'hF1};
        step();
        checks++;
        if (occupancy !== 4'b0110) begin errors++; $display("FAIL mid_pre got occ=%b exp 0110", occupancy); end
        noc_in = {32'hF4, 32'hF3};
        reset  = 1'b1;
        step();
        reset      = 1'b0;
        noc_ivalid = 2'b00;
        checks++;
        if (out_valid !== 2'b00 || occupancy !== 4'h0 || noc_oready !== 2'b11 || out_data !== 64'h0) begin
            errors++; $display("FAIL mid_reset got v=%b occ=%h rdy=%b d=%h exp v=00 occ=0 rdy=11 d=0",
                               out_valid, occupancy, noc_oready, out_data);
        end
        step();
        checks++;
        if (out_valid !== 2'b00 || occupancy !== 4'h0) begin
            errors++; $display("FAIL mid_after got v=%b occ=%h exp v=00 occ=0", out_valid, occupancy);
        end
    endtask

    initial begin
        reset         = 1'b1;
        cfg_we        = 1'b0;
        cfg_const_en  = 2'b00;
        cfg_const_val = 64'h0;
        noc_ivalid    = 2'b00;
        noc_in        = 64'h0;
        consume       = 2'b00;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_const();
        test_const_off();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
